gaussian_prod_round: RTL and testbench

GAUSSIAN_PROD_ROUND -- requirements
Module: gaussian_prod_round

---
 rtl/gaussian_prod_round.sv | 128 ++++++++++++
 tb/tb_gaussian_prod_round.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_prod_round.sv
// Rounding/output stage for the 16x18 Gaussian multiplier.
// Tracks operand issues through the multiplier's 2-cycle latency, rounds the
// 34-bit product half-up by SHIFT bits and buffers results in a small FIFO.
// in_ready only grants an issue when a FIFO slot is guaranteed, because the
// multiplier pipeline cannot be stalled.
// Optional macro GAUSSIAN_ROUND_SAT_EN: clamp out-of-range samples and flag
// them on out_sat; otherwise samples wrap to OUT_W bits and out_sat is 0.
module gaussian_prod_round #(
   parameter int unsigned SHIFT = 16,
   parameter int unsigned OUT_W = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [33:0]      p,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_sat,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = CW + 1;
   localparam int unsigned RW = 35;
   localparam logic signed [RW-1:0] HALF = RW'(64'd1 << (SHIFT - 1));

   logic                   v0;
   logic                   v1;
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [CW-1:0]          occ;
   logic [OUT_W-1:0]       mem_data [DEPTH];
   logic                   issue;
   logic                   push;
   logic                   pop;
   logic [SW-1:0]          committed;
   logic signed [RW-1:0]   p_ext;
   logic signed [RW-1:0]   r;
   logic [OUT_W-1:0]       wr_data;

   // Slots already promised: buffered samples plus products still in flight.
   assign committed = SW'(occ) + SW'(v0) + SW'(v1);
   assign in_ready  = !rst && (committed < SW'(DEPTH));
   assign issue     = in_valid && in_ready;
   assign push      = v1;
   assign out_valid = (occ != '0);
   assign pop       = out_valid && out_ready;

   // Round half-up in 35-bit signed arithmetic so the offset never overflows.
   assign p_ext = {p[33], p};
   assign r     = (p_ext + HALF) >>> SHIFT;

`ifdef GAUSSIAN_ROUND_SAT_EN
   localparam logic signed [RW-1:0] MAXV = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [RW-1:0] MINV = RW'(-(64'sd1 <<< (OUT_W - 1)));

   logic wr_sat;
   logic mem_sat [DEPTH];

   // Clamp the rounded value into the signed OUT_W range.
   always_comb begin
      wr_data = r[OUT_W-1:0];
      wr_sat  = 1'b0;
      if (r > MAXV) begin
         wr_data = MAXV[OUT_W-1:0];
         wr_sat  = 1'b1;
      end else if (r < MINV) begin
         wr_data = MINV[OUT_W-1:0];
         wr_sat  = 1'b1;
      end
   end

   assign out_sat = mem_sat[rd_ptr];

   // Saturation flags travel alongside the sample storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_sat[i] <= 1'b0;
      end else if (push) begin
         mem_sat[wr_ptr] <= wr_sat;
      end
   end
`else
   logic unused_r_high;

   // Two's-complement wrap: keep only the low OUT_W bits.
   assign wr_data       = r[OUT_W-1:0];
   assign unused_r_high = ^r[RW-1:OUT_W];
   assign out_sat       = 1'b0;
`endif

   assign out_data = mem_data[rd_ptr];

   // Issue tracking, FIFO pointers, occupancy and sample storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v0     <= 1'b0;
         v1     <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_data[i] <= '0;
      end else begin
         v0 <= issue;
         v1 <= v0;
         if (push) begin
            mem_data[wr_ptr] <= wr_data;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   occ <= occ + CW'(1);
            2'b01:   occ <= occ - CW'(1);
            default: occ <= occ;
         endcase
      end
   end

   // A push into a full FIFO without a matching pop would drop a sample.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && (occ == CW'(DEPTH))));

endmodule

// File: tb/tb_gaussian_prod_round.sv
// Scoreboard bench for gaussian_prod_round (SHIFT=16, OUT_W=16, DEPTH=4).
// Define GAUSSIAN_ROUND_SAT_EN for both RTL and bench to exercise clamping.
module tb_gaussian_prod_round;

   localparam int unsigned SHIFT = 16;
   localparam int unsigned OUT_W = 16;
   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [OUT_W-1:0] d;
      logic             s;
      int               avail;
   } exp_t;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic signed [33:0] p;
   logic [OUT_W-1:0]   out_data;
   logic               out_sat;
   logic               out_valid;
   logic               out_ready;

   int     n_vec = 0;
   int     n_err = 0;
   int     cyc = 0;
   int     outstanding = 0;
   int     n_issue = 0;
   exp_t   q[$];
   bit     sch_v [3];
   longint sch_p [3];

   gaussian_prod_round #(.SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .p         (p),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: floor((p + 2^(SHIFT-1)) / 2^SHIFT), then clamp or wrap.
   function automatic void model(input longint pv, output logic [OUT_W-1:0] d, output logic s);
      longint r;
      longint maxv;
      longint minv;
      r    = (pv + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
      maxv = (longint'(1) <<< (OUT_W - 1)) - 1;
      minv = -(longint'(1) <<< (OUT_W - 1));
`ifdef GAUSSIAN_ROUND_SAT_EN
      if (r > maxv) begin
         d = OUT_W'(maxv);
         s = 1'b1;
      end else if (r < minv) begin
         d = OUT_W'(minv);
         s = 1'b1;
      end else begin
         d = OUT_W'(r);
         s = 1'b0;
      end
`else
      if (maxv < minv) s = 1'b1;
      else s = 1'b0;
      d = OUT_W'(r);
`endif
   endfunction

   function automatic longint rand_prod();
      logic signed [33:0] t;
      case ($urandom_range(2))
         0: begin
            t = 34'({$urandom(), $urandom()});
            return longint'(t);
         end
         1: return ((longint'($urandom_range(65540)) - 32770) <<< 16)
                   + longint'($urandom_range(65535));
         default: return ((longint'($urandom_range(65540)) - 32770) <<< 16)
                   + 32768 - longint'($urandom_range(1));
      endcase
   endfunction

   // One cycle of stimulus; the bench also plays the 2-cycle multiplier.
   task automatic step(input bit iv, input bit ordy, input bit use_p, input longint pv);
      longint             prod;
      logic [OUT_W-1:0]   ed;
      logic               es;
      logic signed [33:0] junk;
      @(posedge clk);
      #1;
      sch_v[0] = sch_v[1]; sch_p[0] = sch_p[1];
      sch_v[1] = sch_v[2]; sch_p[1] = sch_p[2];
      sch_v[2] = 1'b0;
      junk = 34'({$urandom(), $urandom()});
      p = sch_v[0] ? 34'(sch_p[0]) : junk;
      in_valid  = iv;
      out_ready = ordy;
      if (!rst) check("in_ready", longint'(in_ready), longint'(outstanding < int'(DEPTH)));
      if (iv && in_ready) begin
         prod = use_p ? pv : rand_prod();
         sch_v[2] = 1'b1;
         sch_p[2] = prod;
         model(prod, ed, es);
         q.push_back('{d: ed, s: es, avail: cyc + 3});
         outstanding++;
         n_issue++;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && outstanding > 0; i++) step(1'b0, 1'b1, 1'b0, 0);
      check("drain_left", longint'(outstanding), 0);
   endtask

   // Monitor: compares every presented/accepted sample with the scoreboard.
   initial begin
      exp_t e;
      bit   exp_v;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_v = (q.size() > 0) && (q[0].avail <= cyc);
            check("out_valid", longint'(out_valid), longint'(exp_v));
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  check("spurious_out", longint'(out_valid), 0);
               end else begin
                  e = q.pop_front();
                  check("out_data", longint'(out_data), longint'(e.d));
                  check("out_sat", longint'(out_sat), longint'(e.s));
                  outstanding--;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      longint dir [10];
      dir = '{98304, -98304, -32768, longint'(1) <<< 32, -(longint'(1) <<< 32),
              (longint'(32767) <<< 16) + 32768, (longint'(32767) <<< 16) + 32767,
              -(longint'(32768) <<< 16) - 32769, -(longint'(1) <<< 33),
              (longint'(1) <<< 33) - 1};
      for (int i = 0; i < 3; i++) begin sch_v[i] = 1'b0; sch_p[i] = 0; end
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; p = '0;
      #1;
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_in_ready", longint'(in_ready), 0);
      check("rst_out_data", longint'(out_data), 0);
      check("rst_out_sat", longint'(out_sat), 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // Directed rounding and range boundaries.
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, dir[i]);
      drain();

      // Backpressure: only DEPTH issues granted while the consumer stalls.
      n_issue = 0;
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 0);
      check("fill_issues", longint'(n_issue), longint'(DEPTH));
      drain();

      // Random traffic.
      for (int i = 0; i < 1500; i++)
         step(1'($urandom_range(1)), ($urandom_range(9) < 7), 1'b0, 0);
      drain();

      // Reset with buffered samples and one product still in the multiplier.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 0);
      @(posedge clk);
      #3 rst = 1'b1;
      in_valid = 1'b0;
      #1;
      check("midrst_out_valid", longint'(out_valid), 0);
      check("midrst_in_ready", longint'(in_ready), 0);
      check("midrst_out_data", longint'(out_data), 0);
      q.delete();
      outstanding = 0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 0);

      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
